// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator front-panel sequencer.
// Imported by the sequencer top and by anything observing its debug struct.
package calc_pkg;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    SHOW    = 3'd4,
    ERR     = 3'd5
  } state_t;

  // Snapshot of sequencer internals for checkers and bring-up probes.
  typedef struct packed {
    state_t     state;
    logic [1:0] key_stable;
  } dbg_t;

  localparam logic [1:0] DISP_LIVE = 2'd0;
  localparam logic [1:0] DISP_RES  = 2'd1;
  localparam logic [1:0] DISP_ERR  = 2'd2;

  localparam logic [3:0] OP_NONE = 4'hF;

  localparam logic [2:0] LED_A    = 3'b110;
  localparam logic [2:0] LED_B    = 3'b101;
  localparam logic [2:0] LED_BUSY = 3'b011;
  localparam logic [2:0] LED_ERR  = 3'b000;

endpackage

// File: rtl/key_debounce.sv
// Debounces one active-low push-button: the stable level follows the raw level
// only after DEBOUNCE_CYCLES consecutive differing cycles; o_press pulses on 1->0.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_stable,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_stable;
  logic          r_press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b1;
      r_press  <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (i_raw == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt    <= '0;
        r_stable <= i_raw;
        // Registered alongside the level change so the pulse lines up with it.
        r_press  <= r_stable & ~i_raw;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_press  = r_press;

endmodule

// File: rtl/calc_sequencer.sv
// Front-panel controller: debounced ENTER/CLEAR capture operands and opcode,
// start the ALU, wait for done with a timeout, and drive display and LEDs.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int RES_W           = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       key,
  input  logic [3:0]       in_number,
  input  logic [3:0]       arif,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [RES_W-1:0] alu_result,
  output logic [RES_W-1:0] disp_value,
  output logic [1:0]       disp_mode,
  output logic [2:0]       led,
  output dbg_t             dbg
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]       w_key_stable;
  logic [1:0]       w_key_press;
  logic             w_enter_ev;
  logic             w_clear_ev;
  logic [3:0]       w_sw;
  logic [RES_W-1:0] w_live;
  logic [TW-1:0]    w_tmo_next;

  state_t           r_state;
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic [3:0]       r_op;
  logic             r_start;
  logic [RES_W-1:0] r_disp;
  logic [1:0]       r_mode;
  logic [2:0]       r_led;
  logic [TW-1:0]    r_tmo;

  for (genvar g = 0; g < 2; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk      (clk),
      .rst      (rst),
      .i_raw    (key[g]),
      .o_stable (w_key_stable[g]),
      .o_press  (w_key_press[g])
    );
  end

  // CLEAR has priority; a coincident ENTER is discarded.
  assign w_clear_ev = w_key_press[1];
  assign w_enter_ev = w_key_press[0] & ~w_key_press[1];
  assign w_sw       = ~in_number;
  assign w_live     = {{(RES_W-4){1'b0}}, w_sw};
  assign w_tmo_next = r_tmo + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ENTER_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_NONE;
      r_start <= 1'b0;
      r_disp  <= '0;
      r_mode  <= DISP_LIVE;
      r_led   <= LED_A;
      r_tmo   <= '0;
    end else begin
      r_start <= 1'b0;
      if (w_clear_ev) begin
        r_state <= ENTER_A;
        r_op    <= OP_NONE;
        r_mode  <= DISP_LIVE;
        r_led   <= LED_A;
        r_disp  <= w_live;
      end else begin
        case (r_state)
          ENTER_A: begin
            r_disp <= w_live;
            r_mode <= DISP_LIVE;
            r_led  <= LED_A;
            if (w_enter_ev) begin
              r_a     <= w_sw;
              r_state <= ENTER_B;
              r_led   <= LED_B;
            end
          end
          ENTER_B: begin
            r_disp <= w_live;
            r_mode <= DISP_LIVE;
            r_led  <= LED_B;
            if (w_enter_ev) begin
              if (arif != OP_NONE) begin
                r_b     <= w_sw;
                r_op    <= arif;
                r_start <= 1'b1;
                r_led   <= LED_BUSY;
                r_state <= ISSUE;
              end else begin
                r_state <= ERR;
                r_led   <= LED_ERR;
                r_mode  <= DISP_ERR;
                r_disp  <= '1;
              end
            end
          end
          ISSUE: begin
            r_tmo   <= '0;
            r_led   <= LED_BUSY;
            r_state <= WAIT;
          end
          WAIT: begin
            r_led <= LED_BUSY;
            if (alu_done) begin
              r_disp  <= alu_result;
              r_mode  <= DISP_RES;
              r_state <= SHOW;
            end else if (w_tmo_next == TW'(TIMEOUT_CYCLES)) begin
              r_state <= ERR;
              r_led   <= LED_ERR;
              r_mode  <= DISP_ERR;
              r_disp  <= '1;
            end else begin
              r_tmo <= w_tmo_next;
            end
          end
          SHOW: begin
            r_led  <= LED_BUSY;
            r_mode <= DISP_RES;
            if (w_enter_ev) begin
              r_a     <= r_disp[3:0];
              r_state <= ENTER_B;
              r_led   <= LED_B;
              r_mode  <= DISP_LIVE;
              r_disp  <= w_live;
            end
          end
          ERR: begin
            r_led  <= LED_ERR;
            r_mode <= DISP_ERR;
            r_disp <= '1;
            if (w_enter_ev) begin
              r_state <= ENTER_A;
              r_led   <= LED_A;
              r_mode  <= DISP_LIVE;
              r_disp  <= w_live;
            end
          end
          default: r_state <= ENTER_A;
        endcase
      end
    end
  end

  assign alu_a          = r_a;
  assign alu_b          = r_b;
  assign alu_op         = r_op;
  assign alu_start      = r_start;
  assign disp_value     = r_disp;
  assign disp_mode      = r_mode;
  assign led            = r_led;
  assign dbg.state      = r_state;
  assign dbg.key_stable = w_key_stable;

endmodule
